ball_motion: RTL

Per-ball kinematics engine: holds one ball's fixed-point position and velocity, advances them once per video frame, applies friction, and accepts velocity replacements from the collision path and from a cue hit. It is the consumer end of the hit controller: it takes the controller's velocity-out and collision-occurred outputs and produces the position and velocity the controller reads back. There is one instance per ball (white, red).

---
 rtl/ball_motion_if.sv | 36 +++
 rtl/ball_motion.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ball_motion_if.sv
// Signal bundle between the hit controller / cue logic and one ball_motion instance.
// Latency: n/a (wires only).
// Backpressure: none; every input is a single-cycle pulse with its data alongside.
interface ball_motion_if;
    logic               startOfFrame;
    logic               collisionOccurred;
    logic signed [10:0] ballVelXIn;
    logic signed [10:0] ballVelYIn;
    logic               hitRequest;
    logic signed [10:0] hitVelX;
    logic signed [10:0] hitVelY;
    logic               sunk;
    logic               respawn;
    logic signed [10:0] ballTopLeftPosX;
    logic signed [10:0] ballTopLeftPosY;
    logic signed [10:0] ballVelX;
    logic signed [10:0] ballVelY;
    logic               ballMoving;
    logic               ballHidden;

    // Controller side: drives pulses and velocities, reads back ball state
    modport master (
        output startOfFrame, collisionOccurred, ballVelXIn, ballVelYIn,
        output hitRequest, hitVelX, hitVelY, sunk, respawn,
        input  ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY,
        input  ballMoving, ballHidden
    );

    // Ball side: consumes pulses, presents registered position/velocity
    modport slave (
        input  startOfFrame, collisionOccurred, ballVelXIn, ballVelYIn,
        input  hitRequest, hitVelX, hitVelY, sunk, respawn,
        output ballTopLeftPosX, ballTopLeftPosY, ballVelX, ballVelY,
        output ballMoving, ballHidden
    );
endinterface

// File: rtl/ball_motion.sv
// Per-ball fixed-point kinematics: per-frame position advance, friction, border clamp.
// Latency: outputs change one cycle after startOfFrame / sunk / respawn.
// Backpressure: none; extra collisions/hits while a velocity is pending are dropped.
module ball_motion #(
    parameter int INIT_X    = 100,
    parameter int INIT_Y    = 100,
    parameter int FRAC_BITS = 6,
    parameter int FRICTION  = 2,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479
) (
    input  logic            clk,
    input  logic            reset,
    ball_motion_if.slave    bus
);
    localparam int W = 11 + FRAC_BITS;

    localparam logic signed [W-1:0] LP_INIT_X = W'(INIT_X * (1 << FRAC_BITS));
    localparam logic signed [W-1:0] LP_INIT_Y = W'(INIT_Y * (1 << FRAC_BITS));
    localparam logic signed [W:0]   LP_XMAX_F = (W+1)'(X_MAX * (1 << FRAC_BITS));
    localparam logic signed [W:0]   LP_YMAX_F = (W+1)'(Y_MAX * (1 << FRAC_BITS));
    localparam logic signed [10:0]  LP_FRIC   = 11'(FRICTION);

    typedef enum logic [1:0] {S_IDLE, S_MOVING, S_SUNK} state_t;

    state_t             r_state, w_state_nxt;
    logic signed [W-1:0] r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic signed [10:0] r_vel_x, r_vel_y, w_vel_x_nxt, w_vel_y_nxt;
    logic               r_pend_vld, w_pend_vld_nxt, w_base_vld;
    logic signed [10:0] r_pend_vx, r_pend_vy, w_pend_vx_nxt, w_pend_vy_nxt;
    logic               r_moving, r_hidden;

    logic signed [10:0] w_v0_x, w_v0_y, w_fv_x, w_fv_y;
    logic signed [W:0]  w_sum_x, w_sum_y;

    // Move a velocity component toward zero by FRICTION without crossing zero
    function automatic logic signed [10:0] apply_friction(input logic signed [10:0] v);
        if (v > LP_FRIC)       return v - LP_FRIC;
        else if (v < -LP_FRIC) return v + LP_FRIC;
        else                   return '0;
    endfunction

    assign w_v0_x  = r_pend_vld ? r_pend_vx : r_vel_x;
    assign w_v0_y  = r_pend_vld ? r_pend_vy : r_vel_y;
    assign w_fv_x  = apply_friction(w_v0_x);
    assign w_fv_y  = apply_friction(w_v0_y);
    // One extra bit so a step past either border is visible before clamping
    assign w_sum_x = (W+1)'(r_pos_x) + (W+1)'(w_fv_x);
    assign w_sum_y = (W+1)'(r_pos_y) + (W+1)'(w_fv_y);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, frame update and pending-velocity capture; respawn > sunk > frame
    always_comb begin
        w_state_nxt    = r_state;
        w_pos_x_nxt    = r_pos_x;
        w_pos_y_nxt    = r_pos_y;
        w_vel_x_nxt    = r_vel_x;
        w_vel_y_nxt    = r_vel_y;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_vx_nxt  = r_pend_vx;
        w_pend_vy_nxt  = r_pend_vy;
        w_base_vld     = r_pend_vld;

        if (bus.respawn) begin
            w_state_nxt    = S_IDLE;
            w_pos_x_nxt    = LP_INIT_X;
            w_pos_y_nxt    = LP_INIT_Y;
            w_vel_x_nxt    = '0;
            w_vel_y_nxt    = '0;
            w_pend_vld_nxt = 1'b0;
        end else if (bus.sunk && r_state != S_SUNK) begin
            w_state_nxt    = S_SUNK;
            w_vel_x_nxt    = '0;
            w_vel_y_nxt    = '0;
            w_pend_vld_nxt = 1'b0;
        end else if (r_state != S_SUNK) begin
            if (bus.startOfFrame) begin
                w_vel_x_nxt = w_fv_x;
                w_vel_y_nxt = w_fv_y;
                w_pos_x_nxt = w_sum_x[W-1:0];
                w_pos_y_nxt = w_sum_y[W-1:0];
                // Border clamp is a safety net only: stop the axis dead
                if (w_sum_x < 0) begin
                    w_pos_x_nxt = '0;
                    w_vel_x_nxt = '0;
                end else if (w_sum_x > LP_XMAX_F) begin
                    w_pos_x_nxt = LP_XMAX_F[W-1:0];
                    w_vel_x_nxt = '0;
                end
                if (w_sum_y < 0) begin
                    w_pos_y_nxt = '0;
                    w_vel_y_nxt = '0;
                end else if (w_sum_y > LP_YMAX_F) begin
                    w_pos_y_nxt = LP_YMAX_F[W-1:0];
                    w_vel_y_nxt = '0;
                end
                w_state_nxt = (w_vel_x_nxt != 0 || w_vel_y_nxt != 0) ? S_MOVING : S_IDLE;
                // Pending is consumed here, so a coincident pulse lands in the next frame
                w_base_vld  = 1'b0;
            end
            w_pend_vld_nxt = w_base_vld;
            if (bus.collisionOccurred && !w_base_vld) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_vx_nxt  = bus.ballVelXIn;
                w_pend_vy_nxt  = bus.ballVelYIn;
            end else if (bus.hitRequest && r_state == S_IDLE && !w_base_vld) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_vx_nxt  = bus.hitVelX;
                w_pend_vy_nxt  = bus.hitVelY;
            end
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos_x    <= LP_INIT_X;
            r_pos_y    <= LP_INIT_Y;
            r_vel_x    <= '0;
            r_vel_y    <= '0;
            r_pend_vld <= 1'b0;
            r_pend_vx  <= '0;
            r_pend_vy  <= '0;
            r_moving   <= 1'b0;
            r_hidden   <= 1'b0;
        end else begin
            r_pos_x    <= w_pos_x_nxt;
            r_pos_y    <= w_pos_y_nxt;
            r_vel_x    <= w_vel_x_nxt;
            r_vel_y    <= w_vel_y_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_vx  <= w_pend_vx_nxt;
            r_pend_vy  <= w_pend_vy_nxt;
            r_moving   <= (w_state_nxt == S_MOVING);
            r_hidden   <= (w_state_nxt == S_SUNK);
        end
    end

    // Integer pixel position is the fixed-point value with its fraction dropped
    assign bus.ballTopLeftPosX = r_pos_x[W-1:FRAC_BITS];
    assign bus.ballTopLeftPosY = r_pos_y[W-1:FRAC_BITS];
    assign bus.ballVelX        = r_vel_x;
    assign bus.ballVelY        = r_vel_y;
    assign bus.ballMoving      = r_moving;
    assign bus.ballHidden      = r_hidden;
endmodule
